// File: rtl/regfile_scb.sv
// regfile_scb
//   Integer register file with a load scoreboard for the 3-stage RISC-V core.
//   It has two combinational read ports and two write ports:
//   WB0 carries ALU results and WB1 carries load returns.
//   A per-register pending bit lets decode stall on outstanding loads.
//
// Ports
//   clock, rst          rising-edge clock, asynchronous active-high reset
//   rs1_addr/rs2_addr   read addresses
//   rs1data/rs2data     read data (combinational)
//   rs1_busy/rs2_busy   registered pending bit of the read addresses
//   wen0/waddr0/wdata0  WB0 (ALU) write port
//   wen1/waddr1/wdata1  WB1 (load) write port; also retires the pending bit
//   issue_ld/issue_rd   load issue; marks issue_rd pending
//   pend_cnt            number of pending registers
//   sb_err              sticky scoreboard protocol error
module regfile_scb #(
    parameter int          XLEN    = 32,
    parameter int          NREG    = 32,
    parameter int          AW      = $clog2(NREG),
    parameter int          SP_IDX  = 2,
    parameter logic [31:0] SP_INIT = 32'h0001_FFFF,
    parameter bit          BYPASS  = 1'b1
) (
    input  logic            clock,
    input  logic            rst,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1data,
    output logic [XLEN-1:0] rs2data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            wen0,
    input  logic [AW-1:0]   waddr0,
    input  logic [XLEN-1:0] wdata0,
    input  logic            wen1,
    input  logic [AW-1:0]   waddr1,
    input  logic [XLEN-1:0] wdata1,
    input  logic            issue_ld,
    input  logic [AW-1:0]   issue_rd,
    output logic [AW:0]     pend_cnt,
    output logic            sb_err
);

    localparam logic [XLEN-1:0] SP_RST = XLEN'(SP_INIT);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] pend;
    logic [NREG-1:0] pend_nxt;
    logic [AW:0]     cnt_nxt;
    logic            err_evt;

    logic we0, we1;
    assign we0 = wen0 && (waddr0 != '0);
    assign we1 = wen1 && (waddr1 != '0);

    // Read path: x0 is hard zero; bypass prefers WB0 because it is the younger instruction.
    function automatic logic [XLEN-1:0] rd_port(input logic [AW-1:0] a);
        logic [XLEN-1:0] v;
        v = regs[a];
        if (a == '0)
            v = '0;
        else if (BYPASS && we0 && (waddr0 == a))
            v = wdata0;
        else if (BYPASS && we1 && (waddr1 == a))
            v = wdata1;
        return v;
    endfunction

    always_comb begin
        rs1data  = rd_port(rs1_addr);
        rs2data  = rd_port(rs2_addr);
        rs1_busy = pend[rs1_addr];
        rs2_busy = pend[rs2_addr];
    end

    // Scoreboard next state: clear first, then set, so a same-cycle set wins.
    always_comb begin
        pend_nxt = pend;
        if (we1)
            pend_nxt[waddr1] = 1'b0;
        if (issue_ld && (issue_rd != '0))
            pend_nxt[issue_rd] = 1'b1;
        pend_nxt[0] = 1'b0;

        cnt_nxt = '0;
        for (int i = 0; i < NREG; i++)
            cnt_nxt = cnt_nxt + (AW+1)'(pend_nxt[i]);

        err_evt = 1'b0;
        if (issue_ld && (issue_rd != '0) && pend[issue_rd] && !(we1 && (waddr1 == issue_rd)))
            err_evt = 1'b1;
        if (we1 && !pend[waddr1])
            err_evt = 1'b1;
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++)
                regs[r] <= (r == SP_IDX) ? SP_RST : '0;
            pend     <= '0;
            pend_cnt <= '0;
            sb_err   <= 1'b0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (we0 && (waddr0 == AW'(r)))
                    regs[r] <= wdata0;
                else if (we1 && (waddr1 == AW'(r)))
                    regs[r] <= wdata1;
            end
            pend     <= pend_nxt;
            pend_cnt <= cnt_nxt;
            if (err_evt)
                sb_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_scb.sv
module tb_regfile_scb;

    logic        clock = 1'b0;
    logic        rst   = 1'b1;
    logic [4:0]  rs1_addr = '0, rs2_addr = '0;
    logic [31:0] rs1data, rs2data;
    logic        rs1_busy, rs2_busy;
    logic        wen0 = 1'b0, wen1 = 1'b0, issue_ld = 1'b0;
    logic [4:0]  waddr0 = '0, waddr1 = '0, issue_rd = '0;
    logic [31:0] wdata0 = '0, wdata1 = '0;
    logic [5:0]  pend_cnt;
    logic        sb_err;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_scb dut (
        .clock(clock), .rst(rst),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1data(rs1data), .rs2data(rs2data),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
        .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
        .issue_ld(issue_ld), .issue_rd(issue_rd),
        .pend_cnt(pend_cnt), .sb_err(sb_err)
    );

    always #5 clock = ~clock;

    task automatic idle();
        wen0 = 0; wen1 = 0; issue_ld = 0;
        waddr0 = 0; waddr1 = 0; issue_rd = 0;
        wdata0 = 0; wdata1 = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        rst = 1;
        #12;
        for (int a = 0; a < 32; a++) begin
            rs1_addr = 5'(a);
            rs2_addr = 5'(a);
            #1;
            n_checks++;
            if (rs1data !== ((a == 2) ? 32'h0001_FFFF : 32'h0)) begin
                n_fail++;
                $display("FAIL reset_rs1 x%0d got %h exp %h", a, rs1data, (a == 2) ? 32'h0001_FFFF : 32'h0);
            end
            n_checks++;
            if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_busy x%0d got %b%b exp 00", a, rs1_busy, rs2_busy);
            end
        end
        n_checks++;
        if (pend_cnt !== 6'd0 || sb_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_cnt_err got %0d/%b exp 0/0", pend_cnt, sb_err);
        end
        @(negedge clock);
        rst = 0;
    endtask

    task automatic test_bypass();
        @(negedge clock);
        wen0 = 1; waddr0 = 5; wdata0 = 32'hDEAD_BEEF;
        rs1_addr = 5; rs2_addr = 5;
        #1;
        n_checks++;
        if (rs1data !== 32'hDEAD_BEEF || rs2data !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL bypass_wb0 got %h/%h exp deadbeef", rs1data, rs2data);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (rs1data !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL stored_x5 got %h exp deadbeef", rs1data);
        end
        n_checks++;
        if (sb_err !== 1'b0) begin
            n_fail++;
            $display("FAIL wb0_no_err got %b exp 0", sb_err);
        end
    endtask

    task automatic test_dual_write();
        // make x7 pending so the WB1 write is legal
        @(negedge clock);
        issue_ld = 1; issue_rd = 7;
        tick();
        idle();
        @(negedge clock);
        wen0 = 1; waddr0 = 7; wdata0 = 32'h1;
        wen1 = 1; waddr1 = 7; wdata1 = 32'h2;
        rs1_addr = 7; rs2_addr = 0;
        #1;
        n_checks++;
        if (rs1data !== 32'h1) begin
            n_fail++;
            $display("FAIL bypass_prio got %h exp 1", rs1data);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (rs1data !== 32'h1 || rs1_busy !== 1'b0 || pend_cnt !== 6'd0 || sb_err !== 1'b0) begin
            n_fail++;
            $display("FAIL dual_write got %h busy=%b cnt=%0d err=%b exp 1/0/0/0", rs1data, rs1_busy, pend_cnt, sb_err);
        end
        @(negedge clock);
        wen0 = 1; waddr0 = 0; wdata0 = 32'hFFFF_FFFF;
        rs1_addr = 0;
        #1;
        n_checks++;
        if (rs1data !== 32'h0) begin
            n_fail++;
            $display("FAIL x0_bypass got %h exp 0", rs1data);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (rs1data !== 32'h0) begin
            n_fail++;
            $display("FAIL x0_write got %h exp 0", rs1data);
        end
    endtask

    task automatic test_scoreboard();
        @(negedge clock);
        issue_ld = 1; issue_rd = 9; rs1_addr = 9;
        #1;
        n_checks++;
        if (rs1_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_same_cycle got %b exp 0", rs1_busy);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (rs1_busy !== 1'b1 || pend_cnt !== 6'd1) begin
            n_fail++;
            $display("FAIL issue_x9 got busy=%b cnt=%0d exp 1/1", rs1_busy, pend_cnt);
        end
        @(negedge clock);
        wen1 = 1; waddr1 = 9; wdata1 = 32'h55;
        #1;
        n_checks++;
        if (rs1data !== 32'h55 || rs1_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL wb1_bypass got %h busy=%b exp 55/1", rs1data, rs1_busy);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (rs1data !== 32'h55 || rs1_busy !== 1'b0 || pend_cnt !== 6'd0 || sb_err !== 1'b0) begin
            n_fail++;
            $display("FAIL retire_x9 got %h busy=%b cnt=%0d err=%b exp 55/0/0/0", rs1data, rs1_busy, pend_cnt, sb_err);
        end
    endtask

    task automatic test_set_clear();
        @(negedge clock);
        issue_ld = 1; issue_rd = 9; rs1_addr = 9;
        tick();
        idle();
        @(negedge clock);
        wen1 = 1; waddr1 = 9; wdata1 = 32'h66;
        issue_ld = 1; issue_rd = 9;
        tick();
        idle();
        #1;
        n_checks++;
        if (rs1_busy !== 1'b1 || pend_cnt !== 6'd1 || sb_err !== 1'b0 || rs1data !== 32'h66) begin
            n_fail++;
            $display("FAIL set_wins got busy=%b cnt=%0d err=%b data=%h exp 1/1/0/66", rs1_busy, pend_cnt, sb_err, rs1data);
        end
        @(negedge clock);
        wen1 = 1; waddr1 = 9; wdata1 = 32'h77;
        tick();
        idle();
        @(negedge clock);
        issue_ld = 1; issue_rd = 0; rs1_addr = 0;
        tick();
        idle();
        #1;
        n_checks++;
        if (rs1_busy !== 1'b0 || pend_cnt !== 6'd0 || sb_err !== 1'b0) begin
            n_fail++;
            $display("FAIL x0_never_pending got busy=%b cnt=%0d err=%b exp 0/0/0", rs1_busy, pend_cnt, sb_err);
        end
    endtask

    task automatic test_sb_err();
        @(negedge clock);
        issue_ld = 1; issue_rd = 3; rs1_addr = 3;
        tick();
        @(negedge clock);
        issue_ld = 1; issue_rd = 10;
        tick();
        idle();
        #1;
        n_checks++;
        if (pend_cnt !== 6'd2 || sb_err !== 1'b0) begin
            n_fail++;
            $display("FAIL two_pending got cnt=%0d err=%b exp 2/0", pend_cnt, sb_err);
        end
        @(negedge clock);
        issue_ld = 1; issue_rd = 3;
        tick();
        idle();
        #1;
        n_checks++;
        if (sb_err !== 1'b1 || pend_cnt !== 6'd2) begin
            n_fail++;
            $display("FAIL double_issue got err=%b cnt=%0d exp 1/2", sb_err, pend_cnt);
        end
        tick();
        tick();
        n_checks++;
        if (sb_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky got %b exp 1", sb_err);
        end
        // async reset mid-cycle, with a write that must be lost
        @(negedge clock);
        #2;
        wen0 = 1; waddr0 = 5; wdata0 = 32'h0000_0123;
        rst = 1;
        #1;
        rs1_addr = 3; rs2_addr = 2;
        #0;
        n_checks++;
        if (sb_err !== 1'b0 || pend_cnt !== 6'd0 || rs1_busy !== 1'b0 || rs2data !== 32'h0001_FFFF) begin
            n_fail++;
            $display("FAIL async_rst got err=%b cnt=%0d busy=%b x2=%h exp 0/0/0/0001ffff", sb_err, pend_cnt, rs1_busy, rs2data);
        end
        tick();
        idle();
        rst = 0;
        rs1_addr = 5; rs2_addr = 7;
        #1;
        n_checks++;
        if (rs1data !== 32'h0 || rs2data !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_clears_regs got %h/%h exp 0/0", rs1data, rs2data);
        end
    endtask

    task automatic test_wb1_unpending();
        @(negedge clock);
        wen1 = 1; waddr1 = 8; wdata1 = 32'h77; rs1_addr = 8;
        tick();
        idle();
        #1;
        n_checks++;
        if (sb_err !== 1'b1 || rs1data !== 32'h77 || pend_cnt !== 6'd0) begin
            n_fail++;
            $display("FAIL wb1_unpending got err=%b data=%h cnt=%0d exp 1/77/0", sb_err, rs1data, pend_cnt);
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_bypass();
        test_dual_write();
        test_scoreboard();
        test_set_clear();
        test_sb_err();
        test_wb1_unpending();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
